reg_writeback: RTL and testbench

Writeback stage for the RV32I core and the single writer of the register file's write port (`RegWrite`, `Rd`, `Write_data`). It accepts single-cycle ALU results and one outstanding load at a time. It formats load data by width, sign- or zero-extends it, and resolves same-cycle ALU/load contention by holding the load result for one cycle. All register-file write outputs are registered.

---
 rtl/reg_writeback.sv | 174 +++++++++++++++++
 tb/tb_reg_writeback.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Writeback stage: sole writer of the register-file write port.
// Merges single-cycle ALU results with one outstanding formatted load.
module reg_writeback #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_stall,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  output logic        ld_ready,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  output logic        ld_err,
  output logic        RegWrite,
  output logic [4:0]  Rd,
  output logic [31:0] Write_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  lrd_q, lrd_d;
  logic [2:0]  lf3_q, lf3_d;
  logic [1:0]  llo_q, llo_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        hold_err_q, hold_err_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt_data;
  logic        fmt_err;
  logic        alu_take;

  assign ld_ready   = (state_q == IDLE);
  assign mem_rready = (state_q == WAIT);
  assign alu_stall  = (state_q == HOLD);
  assign RegWrite   = we_q;
  assign Rd         = rd_q;
  assign Write_data = wdata_q;
  assign ld_err     = err_q;

  // Select the addressed lane and extend it according to the captured load type
  always_comb begin
    byte_sel = 8'h00;
    half_sel = llo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    fmt_data = '0;
    fmt_err  = 1'b0;
    case (llo_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (lf3_q)
      3'b000: fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: fmt_data = {24'h0, byte_sel};
      3'b001: begin
        fmt_data = {{16{half_sel[15]}}, half_sel};
        fmt_err  = llo_q[0];
      end
      3'b101: begin
        fmt_data = {16'h0, half_sel};
        fmt_err  = llo_q[0];
      end
      3'b010: begin
        fmt_data = mem_rdata;
        fmt_err  = (llo_q != 2'd0);
      end
      default: fmt_err = 1'b1;
    endcase
  end

  // Next-state, load capture and write-port arbitration (ALU wins ties)
  always_comb begin
    state_d     = state_q;
    lrd_d       = lrd_q;
    lf3_d       = lf3_q;
    llo_d       = llo_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    we_d        = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    err_d       = 1'b0;
    alu_take    = alu_valid && (state_q != HOLD);
    if (alu_take && (alu_rd != 5'd0)) begin
      we_d    = 1'b1;
      rd_d    = alu_rd;
      wdata_d = alu_result;
    end
    case (state_q)
      IDLE: begin
        if (ld_issue) begin
          lrd_d   = ld_rd;
          lf3_d   = ld_funct3;
          llo_d   = ld_addr_lo;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (alu_valid) begin
            hold_data_d = fmt_data;
            hold_err_d  = fmt_err;
            state_d     = HOLD;
          end else begin
            if (fmt_err) begin
              err_d = 1'b1;
            end else if (lrd_q != 5'd0) begin
              we_d    = 1'b1;
              rd_d    = lrd_q;
              wdata_d = fmt_data;
            end
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_err_q) begin
          err_d = 1'b1;
        end else if (lrd_q != 5'd0) begin
          we_d    = 1'b1;
          rd_d    = lrd_q;
          wdata_d = hold_data_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured load context and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lrd_q       <= '0;
      lf3_q       <= '0;
      llo_q       <= '0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrd_q       <= lrd_d;
      lf3_q       <= lf3_d;
      llo_q       <= llo_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: load-format table
// plus hand sequences for ALU, conflict, x0 and reset cases.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_ready;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        ld_err;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;

  int n_vec = 0;
  int n_bad = 0;

  reg_writeback #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_result(alu_result), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_ready(ld_ready), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .ld_err(ld_err), .RegWrite(RegWrite),
    .Rd(Rd), .Write_data(Write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          lat;
    logic        we;
    logic [31:0] data;
    logic        err;
  } ld_vec_t;

  ld_vec_t tv[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{3'b000, 2'd2, 5'd7,  32'h12F0_3456, 0, 1'b1, 32'hFFFF_FFF0, 1'b0};
    tv[1]  = '{3'b100, 2'd2, 5'd7,  32'h12F0_3456, 1, 1'b1, 32'h0000_00F0, 1'b0};
    tv[2]  = '{3'b101, 2'd2, 5'd7,  32'h12F0_3456, 0, 1'b1, 32'h0000_12F0, 1'b0};
    tv[3]  = '{3'b001, 2'd2, 5'd8,  32'h8001_7FFF, 2, 1'b1, 32'hFFFF_8001, 1'b0};
    tv[4]  = '{3'b001, 2'd0, 5'd8,  32'h8001_7FFF, 0, 1'b1, 32'h0000_7FFF, 1'b0};
    tv[5]  = '{3'b000, 2'd1, 5'd10, 32'h8001_7FFF, 0, 1'b1, 32'h0000_007F, 1'b0};
    tv[6]  = '{3'b000, 2'd3, 5'd11, 32'h8001_7FFF, 0, 1'b1, 32'hFFFF_FF80, 1'b0};
    tv[7]  = '{3'b100, 2'd3, 5'd11, 32'h8001_7FFF, 0, 1'b1, 32'h0000_0080, 1'b0};
    tv[8]  = '{3'b010, 2'd0, 5'd31, 32'hCAFE_BABE, 1, 1'b1, 32'hCAFE_BABE, 1'b0};
    tv[9]  = '{3'b001, 2'd1, 5'd12, 32'h1111_2222, 0, 1'b0, 32'h0,         1'b1};
    tv[10] = '{3'b011, 2'd0, 5'd12, 32'h1111_2222, 0, 1'b0, 32'h0,         1'b1};
    tv[11] = '{3'b010, 2'd2, 5'd12, 32'h1111_2222, 0, 1'b0, 32'h0,         1'b1};
    tv[12] = '{3'b101, 2'd3, 5'd12, 32'h1111_2222, 0, 1'b0, 32'h0,         1'b1};
    tv[13] = '{3'b110, 2'd0, 5'd12, 32'h1111_2222, 0, 1'b0, 32'h0,         1'b1};
    tv[14] = '{3'b111, 2'd0, 5'd12, 32'h1111_2222, 0, 1'b0, 32'h0,         1'b1};
    tv[15] = '{3'b010, 2'd0, 5'd0,  32'hFFFF_FFFF, 0, 1'b0, 32'h0,         1'b0};

    rst = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_result = '0;
    ld_issue = 0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0;
    mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_we", 32'(RegWrite), 32'd0);
    chk("rst_rd", 32'(Rd), 32'd0);
    chk("rst_wd", Write_data, 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_rready", 32'(mem_rready), 32'd0);
    chk("rst_stall", 32'(alu_stall), 32'd0);

    alu_valid = 1; alu_rd = 5'd5; alu_result = 32'h2A;
    tick();
    alu_valid = 0;
    chk("alu_we", 32'(RegWrite), 32'd1);
    chk("alu_rd", 32'(Rd), 32'd5);
    chk("alu_wd", Write_data, 32'h2A);
    tick();
    chk("alu_we_off", 32'(RegWrite), 32'd0);

    alu_valid = 1; alu_rd = 5'd0; alu_result = 32'h77;
    tick();
    alu_valid = 0;
    chk("alu_x0_we", 32'(RegWrite), 32'd0);

    for (int i = 0; i < 16; i++) begin
      ld_issue = 1; ld_rd = tv[i].rd;
      ld_funct3 = tv[i].f3; ld_addr_lo = tv[i].lo;
      tick();
      ld_issue = 0;
      chk($sformatf("v%0d_rready", i), 32'(mem_rready), 32'd1);
      for (int w = 0; w < tv[i].lat; w++) tick();
      mem_rvalid = 1; mem_rdata = tv[i].rdata;
      tick();
      mem_rvalid = 0;
      chk($sformatf("v%0d_we", i), 32'(RegWrite), 32'(tv[i].we));
      chk($sformatf("v%0d_err", i), 32'(ld_err), 32'(tv[i].err));
      if (tv[i].we) begin
        chk($sformatf("v%0d_rd", i), 32'(Rd), 32'(tv[i].rd));
        chk($sformatf("v%0d_wd", i), Write_data, tv[i].data);
      end
      chk($sformatf("v%0d_ready", i), 32'(ld_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_we_off", i), 32'(RegWrite), 32'd0);
      chk($sformatf("v%0d_err_off", i), 32'(ld_err), 32'd0);
    end

    ld_issue = 1; ld_rd = 5'd9; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    tick();
    ld_issue = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    alu_valid = 1; alu_rd = 5'd3; alu_result = 32'h11;
    tick();
    mem_rvalid = 0;
    chk("cf1_we", 32'(RegWrite), 32'd1);
    chk("cf1_rd", 32'(Rd), 32'd3);
    chk("cf1_wd", Write_data, 32'h11);
    chk("cf1_stall", 32'(alu_stall), 32'd1);
    chk("cf1_ready", 32'(ld_ready), 32'd0);
    alu_rd = 5'd4; alu_result = 32'h22;
    ld_issue = 1; ld_rd = 5'd13;
    tick();
    ld_issue = 0;
    chk("cf2_we", 32'(RegWrite), 32'd1);
    chk("cf2_rd", 32'(Rd), 32'd9);
    chk("cf2_wd", Write_data, 32'hDEAD_BEEF);
    chk("cf2_stall", 32'(alu_stall), 32'd0);
    chk("cf2_rready", 32'(mem_rready), 32'd0);
    chk("cf2_ready", 32'(ld_ready), 32'd1);
    tick();
    alu_valid = 0;
    chk("cf3_we", 32'(RegWrite), 32'd1);
    chk("cf3_rd", 32'(Rd), 32'd4);
    chk("cf3_wd", Write_data, 32'h22);
    tick();
    chk("cf4_we", 32'(RegWrite), 32'd0);

    ld_issue = 1; ld_rd = 5'd12; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    tick();
    ld_issue = 0;
    chk("rw_rready", 32'(mem_rready), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 0;
    chk("rw_we", 32'(RegWrite), 32'd0);
    chk("rw_ready", 32'(ld_ready), 32'd1);
    chk("rw_rd", 32'(Rd), 32'd0);
    chk("rw_wd", Write_data, 32'd0);
    chk("rw_err", 32'(ld_err), 32'd0);
    tick();
    chk("rw_we2", 32'(RegWrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
